// File: rtl/lck_sweep_ctrl_if.sv
// rtl/lck_sweep_ctrl_if.sv - per-point result stream of the lock-in frequency sweep controller
interface lck_sweep_ctrl_if;
    logic [127:0] M_AXIS_RES_tdata;
    logic         M_AXIS_RES_tvalid;
    logic         M_AXIS_RES_tready;

    modport master (
        output M_AXIS_RES_tdata,
        output M_AXIS_RES_tvalid,
        input  M_AXIS_RES_tready
    );

    modport slave (
        input  M_AXIS_RES_tdata,
        input  M_AXIS_RES_tvalid,
        output M_AXIS_RES_tready
    );
endinterface

// File: rtl/lck_sweep_ctrl.sv
// rtl/lck_sweep_ctrl.sv - lock-in frequency sweep sequencer; LCK_SWEEP_RESTORE_EN adds a final pinc_start rewrite
module lck_sweep_ctrl #(
    parameter int CONFIG_ADDRESS     = 1000,
    parameter int LCK_CONFIG_ADDRESS = 999,
    parameter int AM2_DATA_WIDTH     = 48,
    parameter int LCK_CORRSUM_WIDTH  = 32
) (
    input  logic                                a_clk,
    input  logic                                a_resetn,
    input  logic [31:0]                         config_addr,
    input  logic [511:0]                        config_data,
    output logic [31:0]                         lck_config_addr,
    output logic [511:0]                        lck_config_data,
    input  logic                                axis_deci_clk,
    input  logic [AM2_DATA_WIDTH-1:0]           S_AXIS_A2_tdata,
    input  logic signed [LCK_CORRSUM_WIDTH-1:0] S_AXIS_X_tdata,
    input  logic signed [LCK_CORRSUM_WIDTH-1:0] S_AXIS_Y_tdata,
    lck_sweep_ctrl_if.master                    res,
    output logic                                busy,
    output logic                                done
);
    localparam int A2W = AM2_DATA_WIDTH + 15;
    localparam int XYW = LCK_CORRSUM_WIDTH + 15;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_CFG     = 3'd1;
    localparam logic [2:0] ST_SETTLE  = 3'd2;
    localparam logic [2:0] ST_ACQ     = 3'd3;
    localparam logic [2:0] ST_PUSH    = 3'd4;
    localparam logic [2:0] ST_NEXT    = 3'd5;
`ifdef LCK_SWEEP_RESTORE_EN
    localparam logic [2:0] ST_RESTORE = 3'd6;
    localparam logic [2:0] ST_END     = ST_RESTORE;
`else
    localparam logic [2:0] ST_END     = ST_IDLE;
`endif

    logic [2:0]  state;
    logic [31:0] n_points_r;
    logic [47:0] pinc_start_r;
    logic [47:0] pinc_step_r;
    logic [15:0] dds_n2_r;
    logic [15:0] settle_r;
    logic [3:0]  avg_n2_r;
    logic [31:0] lck_cfg_r;
    logic [31:0] lck_gain_r;

    logic [47:0] pinc;
    logic [31:0] index;
    logic [15:0] settle_cnt;
    logic [16:0] acq_cnt;
    logic        stop_pend;
    logic [511:0] lck_data;

    logic [A2W-1:0]        a2_acc;
    logic signed [XYW-1:0] x_acc;
    logic signed [XYW-1:0] y_acc;
    logic [A2W-1:0]        a2_avg;
    logic signed [XYW-1:0] x_avg;
    logic signed [XYW-1:0] y_avg;

    logic deci_d1, deci_d2, tick;
    logic cfg_wr, cfg_start, cfg_stop;
    logic acq_last, last_point, sweep_end;
    logic [47:0] pinc_next;

    logic unused_cfg_bits;
`ifdef LCK_SWEEP_RESTORE_EN
    assign unused_cfg_bits = ^{config_data[511:288], config_data[223:212],
                               config_data[127:112], config_data[31:2]};
`else
    assign unused_cfg_bits = ^{config_data[511:288], config_data[223:212],
                               config_data[127:112], config_data[31:2], pinc_start_r};
`endif

    function automatic logic [511:0] lck_word(input logic [31:0] cfg, input logic [31:0] gain,
                                              input logic [15:0] n2, input logic [47:0] p);
        logic [511:0] w;
        w          = '0;
        w[31:0]    = cfg;
        w[63:32]   = gain;
        w[79:64]   = n2;
        w[127:80]  = p;
        return w;
    endfunction

    assign tick      = deci_d1 & ~deci_d2;
    assign cfg_wr    = (config_addr == 32'(CONFIG_ADDRESS));
    assign cfg_start = cfg_wr & config_data[0];
    assign cfg_stop  = cfg_wr & config_data[1];

    assign acq_last   = (acq_cnt + 17'd1) == (17'd1 << avg_n2_r);
    assign last_point = (index + 32'd1) == n_points_r;
    assign pinc_next  = pinc + pinc_step_r;

    // Every way out of a running sweep funnels through sweep_end so the optional restore cycle is shared.
    always_comb begin
        sweep_end = 1'b0;
        case (state)
            ST_CFG, ST_SETTLE, ST_ACQ: sweep_end = cfg_stop;
            ST_PUSH:  sweep_end = res.M_AXIS_RES_tready & (stop_pend | cfg_stop);
            ST_NEXT:  sweep_end = cfg_stop | last_point;
            default:  sweep_end = 1'b0;
        endcase
    end

    assign a2_avg = a2_acc >> avg_n2_r;
    assign x_avg  = x_acc >>> avg_n2_r;
    assign y_avg  = y_acc >>> avg_n2_r;

    assign res.M_AXIS_RES_tvalid = (state == ST_PUSH);
    assign res.M_AXIS_RES_tdata  = {index[15:0], y_avg[31:0], x_avg[31:0], a2_avg[47:0]};

    assign busy            = (state != ST_IDLE);
    assign lck_config_data = lck_data;
`ifdef LCK_SWEEP_RESTORE_EN
    assign lck_config_addr = (state == ST_CFG || state == ST_RESTORE) ? 32'(LCK_CONFIG_ADDRESS) : 32'd0;
`else
    assign lck_config_addr = (state == ST_CFG) ? 32'(LCK_CONFIG_ADDRESS) : 32'd0;
`endif

    always_ff @(posedge a_clk or negedge a_resetn) begin
        if (!a_resetn) begin
            state        <= ST_IDLE;
            n_points_r   <= '0;
            pinc_start_r <= '0;
            pinc_step_r  <= '0;
            dds_n2_r     <= '0;
            settle_r     <= '0;
            avg_n2_r     <= '0;
            lck_cfg_r    <= '0;
            lck_gain_r   <= '0;
            pinc         <= '0;
            index        <= '0;
            settle_cnt   <= '0;
            acq_cnt      <= '0;
            stop_pend    <= 1'b0;
            lck_data     <= '0;
            a2_acc       <= '0;
            x_acc        <= '0;
            y_acc        <= '0;
            deci_d1      <= 1'b0;
            deci_d2      <= 1'b0;
            done         <= 1'b0;
        end else begin
            deci_d1 <= axis_deci_clk;
            deci_d2 <= deci_d1;
            done    <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cfg_wr) begin
                        n_points_r   <= config_data[63:32];
                        pinc_start_r <= config_data[111:64];
                        pinc_step_r  <= config_data[175:128];
                        dds_n2_r     <= config_data[191:176];
                        settle_r     <= config_data[207:192];
                        avg_n2_r     <= config_data[211:208];
                        lck_cfg_r    <= config_data[255:224];
                        lck_gain_r   <= config_data[287:256];
                        stop_pend    <= 1'b0;
                        if (cfg_start) begin
                            if (config_data[63:32] == 32'd0) begin
                                done <= 1'b1;
                            end else begin
                                state      <= ST_CFG;
                                pinc       <= config_data[111:64];
                                index      <= '0;
                                settle_cnt <= '0;
                                acq_cnt    <= '0;
                                a2_acc     <= '0;
                                x_acc      <= '0;
                                y_acc      <= '0;
                                lck_data   <= lck_word(config_data[255:224], config_data[287:256],
                                                       config_data[191:176], config_data[111:64]);
                            end
                        end
                    end
                end
                ST_CFG: begin
                    state      <= ST_SETTLE;
                    settle_cnt <= '0;
                end
                ST_SETTLE: begin
                    if (settle_r == 16'd0) begin
                        state <= ST_ACQ;
                    end else if (tick) begin
                        if (settle_cnt + 16'd1 == settle_r) state <= ST_ACQ;
                        settle_cnt <= settle_cnt + 16'd1;
                    end
                end
                ST_ACQ: begin
                    if (tick) begin
                        a2_acc  <= a2_acc + A2W'(S_AXIS_A2_tdata);
                        x_acc   <= x_acc + {{15{S_AXIS_X_tdata[LCK_CORRSUM_WIDTH-1]}}, S_AXIS_X_tdata};
                        y_acc   <= y_acc + {{15{S_AXIS_Y_tdata[LCK_CORRSUM_WIDTH-1]}}, S_AXIS_Y_tdata};
                        acq_cnt <= acq_cnt + 17'd1;
                        if (acq_last) state <= ST_PUSH;
                    end
                end
                ST_PUSH: begin
                    if (cfg_stop) stop_pend <= 1'b1;
                    if (res.M_AXIS_RES_tready) state <= ST_NEXT;
                end
                ST_NEXT: begin
                    pinc    <= pinc_next;
                    index   <= index + 32'd1;
                    acq_cnt <= '0;
                    a2_acc  <= '0;
                    x_acc   <= '0;
                    y_acc   <= '0;
                    if (last_point && !cfg_stop) done <= 1'b1;
                    state    <= ST_CFG;
                    lck_data <= lck_word(lck_cfg_r, lck_gain_r, dds_n2_r, pinc_next);
                end
                default: state <= ST_IDLE;
            endcase
            if (sweep_end) begin
                state <= ST_END;
`ifdef LCK_SWEEP_RESTORE_EN
                lck_data <= lck_word(lck_cfg_r, lck_gain_r, dds_n2_r, pinc_start_r);
`else
                lck_data <= lck_data;
`endif
            end
        end
    end
endmodule

// File: doc/lck_sweep_ctrl.md
LCK_SWEEP_CTRL -- requirements
Module: lck_sweep_ctrl

Interface
REQ-001 Parameter CONFIG_ADDRESS, default 1000: own config_addr match value.
REQ-002 Parameter LCK_CONFIG_ADDRESS, default 999: address driven onto the lock-in config bus.
REQ-003 Parameter AM2_DATA_WIDTH, default 48: A2 input width.
REQ-004 Parameter LCK_CORRSUM_WIDTH, default 32: X/Y input width.
REQ-005 a_clk  in  1  single clock; all logic on its rising edge.
REQ-006 a_resetn  in  1  asynchronous, active-low reset.
REQ-007 config_addr  in  32 / config_data  in  512  own configuration bus.
REQ-008 lck_config_addr  out  32 / lck_config_data  out  512  lock-in configuration bus.
REQ-009 axis_deci_clk  in  1  lock-in result-update strobe.
REQ-010 S_AXIS_A2_tdata  in  AM2_DATA_WIDTH; S_AXIS_X_tdata, S_AXIS_Y_tdata  in  LCK_CORRSUM_WIDTH (signed).
REQ-011 M_AXIS_RES_tdata  out  128 / M_AXIS_RES_tvalid  out  1 / M_AXIS_RES_tready  in  1  per-point result stream.
REQ-012 busy  out  1 / done  out  1  status.

Function
REQ-013 Own config write when config_addr==CONFIG_ADDRESS; fields: [0] start, [1] stop, [63:32] n_points, [111:64] pinc_start, [175:128] pinc_step (mod 2^48), [191:176] dds_n2, [207:192] settle_ticks, [211:208] avg_n2, [255:224] lck_cfg, [287:256] lck_gain.
REQ-014 Parameter fields latch only in IDLE; while busy, only stop is honoured.
REQ-015 Tick = rising edge of axis_deci_clk (registered edge detect, 1-cycle delay).
REQ-016 States: IDLE, CFG, SETTLE, ACQ, PUSH, NEXT.
REQ-017 IDLE -> CFG on start=1 write; start with n_points=0 -> done pulse, stay IDLE, no output.
REQ-018 CFG, exactly 1 cycle: lck_config_addr=LCK_CONFIG_ADDRESS; lck_config_data [31:0]=lck_cfg, [63:32]=lck_gain, [79:64]=dds_n2, [127:80]=current pinc, rest 0; outside CFG lck_config_addr=0 and lck_config_data holds its last value.
REQ-019 SETTLE: count settle_ticks ticks, then ACQ; settle_ticks=0 -> ACQ next cycle; ticks arriving in CFG are ignored.
REQ-020 ACQ: on each of 2^avg_n2 ticks, add A2 (unsigned), X and Y (signed) into accumulators widened by 15 bits; then PUSH.
REQ-021 PUSH result: [47:0]=A2acc>>avg_n2, [79:48]=Xacc>>>avg_n2, [111:80]=Yacc>>>avg_n2, [127:112]=point index[15:0]; tvalid held, tdata stable until tready.
REQ-022 NEXT, 1 cycle: pinc+=pinc_step (wraps mod 2^48), index++, accumulators cleared; index==n_points -> done pulse (1 cycle), IDLE, else CFG.
REQ-023 Stop (or stop together with start) in CFG/SETTLE/ACQ/NEXT -> IDLE next cycle, no output, no done; in PUSH the stop is latched and takes effect after the handshake.
REQ-024 busy=1 in every state except IDLE.

Reset
REQ-025 a_resetn low: state=IDLE, counters/accumulators/index=0, tvalid=0, done=0, busy=0, lck_config_addr=0, lck_config_data=0, latched fields=0; asserting reset mid-sweep aborts immediately.

Configuration
REQ-026 Macro LCK_SWEEP_RESTORE_EN defined: on done or abort, one extra CFG-like cycle rewrites the lock-in with pinc=pinc_start before IDLE (busy stays high during it); undefined: no rewrite, lock-in keeps the last frequency.

Verification
REQ-027 n_points=3, pinc_start=0x1000, step=0x100, settle=2, avg_n2=0, A2=5 -> three CFG writes with pinc 0x1000/0x1100/0x1200, three results with A2=5, index 0..2, one done.
REQ-028 avg_n2=2, X = -4,-4,-4,-8 over the ticks -> result X field = -5 (arithmetic shift of -20).
REQ-029 tready=0 for 50 cycles in PUSH -> tvalid and tdata held constant, no CFG issued.
REQ-030 Stop during SETTLE of point 1 -> IDLE, no result, no done; with LCK_SWEEP_RESTORE_EN defined, one restore write with pinc=pinc_start.
REQ-031 pinc_start=0xFFFF_FFFF_FFF0, step=0x20 -> second point pinc=0x10.
REQ-032 a_resetn pulsed low during ACQ -> all outputs return to reset values asynchronously, before the next clock edge.
